// File: rtl/cic3_decimator_1bit_if.sv
// AXI-Stream style beat channel (tdata/tvalid/tready) shared by the CIC
// decimator input (1-bit modulator stream) and output (PCM samples).
interface cic3_decimator_1bit_if #(
  parameter int DW = 1
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/cic3_decimator_1bit.sv
// Third-order CIC (sinc3) decimator: 1-bit delta-sigma stream in, signed
// WIDTH-bit PCM out, one sample per 2**DECIM_LOG2 accepted beats.
module cic3_decimator_1bit #(
  parameter int WIDTH      = 16,
  parameter int DECIM_LOG2 = 6
) (
  input  logic                  aclk,
  input  logic                  arst,
  cic3_decimator_1bit_if.slave  s_axis_data,
  cic3_decimator_1bit_if.master m_axis_data
);

  localparam int W     = 3 * DECIM_LOG2 + 2;
  localparam int SHIFT = 3 * DECIM_LOG2 - (WIDTH - 1);

  localparam logic [W-1:0]     POS_FULL = {{(W-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [1:0]       WARM_DONE = 2'd2;

  if (3 * DECIM_LOG2 < WIDTH - 1) begin : g_bad_params
    $error("cic3_decimator_1bit: 3*DECIM_LOG2 must be >= WIDTH-1");
  end

  logic signed [W-1:0]     i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic signed [W-1:0]     d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [DECIM_LOG2-1:0]   phase_q, phase_d;
  logic [1:0]              warm_q, warm_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [W-1:0]     x;
  logic signed [W-1:0]     c1, c2, c3, c3_sh;
  logic [WIDTH-1:0]        y;
  logic                    last_phase, s_ready, beat, strobe, produce;

  // Bit 1 maps to +1, bit 0 to -1 (all ones in two's complement).
  assign x = {{(W-1){~s_axis_data.tdata[0]}}, 1'b1};

  assign last_phase = &phase_q;
  // Only the strobe beat needs somewhere to land, so stall just that one.
  assign s_ready    = !(last_phase && out_valid_q && !m_axis_data.tready);
  assign beat       = s_axis_data.tvalid && s_ready;
  assign strobe     = beat && last_phase;
  assign produce    = strobe && (warm_q == WARM_DONE);

  assign s_axis_data.tready = s_ready;
  assign m_axis_data.tdata  = out_data_q;
  assign m_axis_data.tvalid = out_valid_q;

  always_comb begin
    i1_d = i1_q;
    i2_d = i2_q;
    i3_d = i3_q;
    phase_d = phase_q;
    if (beat) begin
      i1_d    = i1_q + x;
      i2_d    = i2_q + i1_d;
      i3_d    = i3_q + i2_d;
      phase_d = phase_q + DECIM_LOG2'(1);
    end
  end

  always_comb begin
    c1    = i3_d - d1_q;
    c2    = c1 - d2_q;
    c3    = c2 - d3_q;
    c3_sh = c3 >>> SHIFT;
    // Only +full-scale overflows the output width; everything else fits.
    y     = (c3_sh == POS_FULL) ? POS_MAX : c3_sh[WIDTH-1:0];
  end

  always_comb begin
    d1_d   = d1_q;
    d2_d   = d2_q;
    d3_d   = d3_q;
    warm_d = warm_q;
    if (strobe) begin
      d1_d = i3_d;
      d2_d = c1;
      d3_d = c2;
      if (warm_q != WARM_DONE) warm_d = warm_q + 2'd1;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (produce) begin
      out_data_d  = y;
      out_valid_d = 1'b1;
    end else if (out_valid_q && m_axis_data.tready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      i1_q        <= '0;
      i2_q        <= '0;
      i3_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      phase_q     <= '0;
      warm_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      i3_q        <= i3_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      phase_q     <= phase_d;
      warm_q      <= warm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_cic3_decimator_1bit.sv
// Directed bench for cic3_decimator_1bit (WIDTH=16, R=64): table of
// periodic streams plus backpressure and mid-frame reset sequences.
module tb_cic3_decimator_1bit;

  typedef struct {
    string             name;
    logic [3:0]        pat;
    bit                gaps;
    int                nout;
    logic signed [15:0] expv;
  } vec_t;

  logic aclk = 1'b0;
  logic arst = 1'b1;

  cic3_decimator_1bit_if #(.DW(1))  s_if ();
  cic3_decimator_1bit_if #(.DW(16)) m_if ();

  cic3_decimator_1bit #(.WIDTH(16), .DECIM_LOG2(6)) dut (
    .aclk        (aclk),
    .arst        (arst),
    .s_axis_data (s_if),
    .m_axis_data (m_if)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int errors  = 0;
  int beats;
  int dut_acc;
  int handshakes;
  int first_hs_beats;
  bit exp_vld;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] expd);
    vectors++;
    if (act !== expd) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expd, $time);
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 1'b0;
    m_if.tready = 1'b1;
    @(posedge aclk); #1;
    arst = 1'b0;
    beats = 0; dut_acc = 0; handshakes = 0; first_hs_beats = -1; exp_vld = 1'b0;
    check("reset_tvalid", {31'd0, m_if.tvalid}, 0);
    check("reset_tdata", $signed(m_if.tdata), 0);
  endtask

  // One clock: drive inputs, compare against the bench model, advance.
  task automatic cyc(input bit din, input bit vld, input bit mrdy, input logic signed [15:0] expv);
    bit exp_srdy, acc, strobe;
    s_if.tdata  = din;
    s_if.tvalid = vld;
    m_if.tready = mrdy;
    #1;
    exp_srdy = !((beats % 64 == 63) && exp_vld && !mrdy);
    check("s_tready", {31'd0, s_if.tready}, {31'd0, exp_srdy});
    check("m_tvalid", {31'd0, m_if.tvalid}, {31'd0, exp_vld});
    if (exp_vld) check("m_tdata", $signed(m_if.tdata), expv);
    if (s_if.tvalid && s_if.tready) dut_acc++;
    if (m_if.tvalid && m_if.tready) begin
      if (handshakes == 0) first_hs_beats = beats;
      handshakes++;
    end
    acc    = vld && exp_srdy;
    strobe = acc && (beats % 64 == 63);
    if (acc) beats++;
    if (strobe && beats >= 192) exp_vld = 1'b1;
    else if (exp_vld && mrdy)   exp_vld = 1'b0;
    @(posedge aclk); #1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"ones",       4'b1111, 1'b0, 4,  16'sd32767};
    vecs[1] = '{"zeros",      4'b0000, 1'b0, 4, -16'sd32768};
    vecs[2] = '{"alt10",      4'b0101, 1'b0, 4,  16'sd0};
    vecs[3] = '{"p1110",      4'b0111, 1'b0, 4,  16'sd16384};
    vecs[4] = '{"ones_gaps",  4'b1111, 1'b1, 3,  16'sd32767};
    vecs[5] = '{"p1110_gaps", 4'b0111, 1'b1, 3,  16'sd16384};

    s_if.tdata = 1'b0; s_if.tvalid = 1'b0; m_if.tready = 1'b1;
    @(posedge aclk); #1;

    foreach (vecs[k]) begin
      logic [3:0] p;
      p = vecs[k].pat;
      do_reset();
      for (int c = 0; c < 4000 && handshakes < vecs[k].nout; c++)
        cyc(p[beats % 4], vecs[k].gaps ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b1, vecs[k].expv);
      check({vecs[k].name, "_nout"}, handshakes, vecs[k].nout);
      check({vecs[k].name, "_first_beat"}, first_hs_beats, 192);
    end

    // Backpressure: hold m_tready low after the first sample.
    do_reset();
    for (int c = 0; c < 400 && !exp_vld; c++) cyc(1'b1, 1'b1, 1'b1, 16'sd32767);
    check("bp_first_ready", dut_acc, 192);
    for (int c = 0; c < 80; c++) cyc(1'b1, 1'b1, 1'b0, 16'sd32767);
    check("bp_stalled_beats", dut_acc, 255);
    check("bp_held_data", $signed(m_if.tdata), 32767);
    for (int c = 0; c < 193; c++) cyc(1'b1, 1'b1, 1'b1, 16'sd32767);
    check("bp_total_out", handshakes + (m_if.tvalid ? 1 : 0), dut_acc / 64 - 2);

    // Mid-frame reset at phase 30, then warmup must repeat.
    for (int c = 0; c < 200 && (beats % 64) != 30; c++) cyc(1'b1, 1'b1, 1'b1, 16'sd32767);
    check("rst_phase", dut_acc % 64, 30);
    do_reset();
    for (int c = 0; c < 400 && handshakes < 2; c++) cyc(1'b1, 1'b1, 1'b1, 16'sd32767);
    check("rst_nout", handshakes, 2);
    check("rst_first_beat", first_hs_beats, 192);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
